// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if
// Bundles the control/issue signals between the FFT stage sequencer and
// the butterfly datapath.
//   i_start                   : start pulse (sampled only when sequencer is idle)
//   i_stall                   : memory-port hold, suppresses issue
//   o_addr1 / o_addr2         : read word addresses of the issued pair
//   o_valid                   : issued pair is valid
//   o_stride                  : butterfly span in samples (2^stage)
//   o_twiddle_offset1..4      : twiddle index for butterflies 1-4
//   o_stage                   : current stage
//   o_busy / o_done           : busy level / one-cycle completion pulse
//   o_cycle_count             : busy-cycle counter, only with FFT_SEQ_PERF_CNT_EN
// Modport master is taken by the sequencer, slave by the datapath side.
interface fft_stage_sequencer_if;
   logic       i_start;
   logic       i_stall;
   logic [7:0] o_addr1;
   logic [7:0] o_addr2;
   logic       o_valid;
   logic [9:0] o_stride;
   logic [8:0] o_twiddle_offset1;
   logic [8:0] o_twiddle_offset2;
   logic [8:0] o_twiddle_offset3;
   logic [8:0] o_twiddle_offset4;
   logic [3:0] o_stage;
   logic       o_busy;
   logic       o_done;
`ifdef FFT_SEQ_PERF_CNT_EN
   logic [15:0] o_cycle_count;

   modport master (
      input  i_start, i_stall,
      output o_addr1, o_addr2, o_valid, o_stride,
             o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
             o_stage, o_busy, o_done, o_cycle_count
   );
   modport slave (
      output i_start, i_stall,
      input  o_addr1, o_addr2, o_valid, o_stride,
             o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
             o_stage, o_busy, o_done, o_cycle_count
   );
`else
   modport master (
      input  i_start, i_stall,
      output o_addr1, o_addr2, o_valid, o_stride,
             o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
             o_stage, o_busy, o_done
   );
   modport slave (
      output i_start, i_stall,
      input  o_addr1, o_addr2, o_valid, o_stride,
             o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
             o_stage, o_busy, o_done
   );
`endif
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Walks an in-place radix-2 FFT of N = 2^LOG2_N samples (4 samples per word)
// stage by stage, issuing one read word pair per cycle with the matching
// stride and four twiddle indices, then idling DRAIN_CYCLES cycles per stage
// so the datapath writeback can retire.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fft_stage_sequencer_if.master (start/stall in, issue/status out)
// Optional feature: define FFT_SEQ_PERF_CNT_EN to add the 16-bit saturating
// busy-cycle counter bus.o_cycle_count.
module fft_stage_sequencer #(
   parameter int LOG2_N       = 10,
   parameter int DRAIN_CYCLES = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   fft_stage_sequencer_if.master        bus
);
   localparam int K_W = LOG2_N - 3;
   localparam int D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [K_W-1:0] K_LAST     = {K_W{1'b1}};
   localparam logic [3:0]     STAGE_LAST = 4'(LOG2_N - 1);
   localparam logic [D_W-1:0] DRAIN_LAST = D_W'(DRAIN_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]     state_r;
   logic [K_W-1:0] k_r;
   logic [D_W-1:0] drain_cnt_r;
   logic [3:0]     stage_r;
   logic           valid_r;
   logic           busy_r;
   logic           done_r;
   logic [7:0]     addr1_r;
   logic [7:0]     addr2_r;
   logic [9:0]     stride_r;
   logic [8:0]     tw_r [4];

   logic [3:0]     sh_s;
   logic [3:0]     tw_sh_s;
   logic [15:0]    k16_s;
   logic [15:0]    sw16_s;
   logic [15:0]    grp16_s;
   logic [15:0]    ofs16_s;
   logic [15:0]    a1_16_s;
   logic [15:0]    r16_s;
   logic [7:0]     addr1_s;
   logic [7:0]     addr2_s;
   logic [8:0]     tw_s [4];

   // Address and twiddle generation for pair k of the current stage.
   always_comb begin
      sh_s    = 4'd0;
      r16_s   = 16'd0;
      // span in words is s/4, but never below one word for stages 0..2
      if (stage_r >= 4'd2) begin
         sh_s = stage_r - 4'd2;
      end else begin
         sh_s = 4'd0;
      end
      tw_sh_s = STAGE_LAST - stage_r;
      k16_s   = 16'(k_r);
      sw16_s  = 16'd1 << sh_s;
      grp16_s = k16_s >> sh_s;
      ofs16_s = k16_s & (sw16_s - 16'd1);
      a1_16_s = ((grp16_s << sh_s) << 1) + ofs16_s;
      addr1_s = 8'(a1_16_s);
      addr2_s = 8'(a1_16_s + sw16_s);
      for (int b = 0; b < 4; b++) begin
         // top-sample position within the butterfly span for butterfly b+1
         case (stage_r)
            4'd0:    r16_s = 16'd0;
            4'd1:    r16_s = 16'(b) & 16'd1;
            default: r16_s = (ofs16_s << 2) + 16'(b);
         endcase
         tw_s[b] = 9'(r16_s << tw_sh_s);
      end
   end

   // Stage/pair FSM with registered issue and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         k_r         <= '0;
         drain_cnt_r <= '0;
         stage_r     <= 4'd0;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         addr1_r     <= 8'd0;
         addr2_r     <= 8'd0;
         stride_r    <= 10'd1;
         for (int b = 0; b < 4; b++) tw_r[b] <= 9'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               valid_r <= 1'b0;
               done_r  <= 1'b0;
               if (bus.i_start) begin
                  state_r     <= ST_ISSUE;
                  stage_r     <= 4'd0;
                  k_r         <= '0;
                  drain_cnt_r <= '0;
                  busy_r      <= 1'b1;
               end else begin
                  busy_r      <= 1'b0;
               end
            end
            ST_ISSUE: begin
               // a stall only drops valid; the last issued pair stays on the bus
               if (!bus.i_stall) begin
                  valid_r  <= 1'b1;
                  addr1_r  <= addr1_s;
                  addr2_r  <= addr2_s;
                  stride_r <= 10'(16'd1 << stage_r);
                  for (int b = 0; b < 4; b++) tw_r[b] <= tw_s[b];
                  k_r      <= k_r + 1'b1;
                  if (k_r == K_LAST) begin
                     state_r     <= ST_DRAIN;
                     drain_cnt_r <= '0;
                  end else begin
                     state_r     <= ST_ISSUE;
                  end
               end else begin
                  valid_r <= 1'b0;
               end
            end
            ST_DRAIN: begin
               valid_r <= 1'b0;
               if (drain_cnt_r == DRAIN_LAST) begin
                  drain_cnt_r <= '0;
                  if (stage_r == STAGE_LAST) begin
                     state_r <= ST_DONE;
                  end else begin
                     stage_r <= stage_r + 4'd1;
                     k_r     <= '0;
                     state_r <= ST_ISSUE;
                  end
               end else begin
                  drain_cnt_r <= drain_cnt_r + 1'b1;
               end
            end
            ST_DONE: begin
               valid_r <= 1'b0;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_addr1           = addr1_r;
   assign bus.o_addr2           = addr2_r;
   assign bus.o_valid           = valid_r;
   assign bus.o_stride          = stride_r;
   assign bus.o_twiddle_offset1 = tw_r[0];
   assign bus.o_twiddle_offset2 = tw_r[1];
   assign bus.o_twiddle_offset3 = tw_r[2];
   assign bus.o_twiddle_offset4 = tw_r[3];
   assign bus.o_stage           = stage_r;
   assign bus.o_busy            = busy_r;
   assign bus.o_done            = done_r;

`ifdef FFT_SEQ_PERF_CNT_EN
   logic [15:0] cycle_cnt_r;

   // Busy-cycle counter: cleared by a start in IDLE, saturating, held while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_r <= 16'd0;
      end else if (state_r == ST_IDLE) begin
         if (bus.i_start) begin
            cycle_cnt_r <= 16'd0;
         end else begin
            cycle_cnt_r <= cycle_cnt_r;
         end
      end else if (cycle_cnt_r != 16'hFFFF) begin
         cycle_cnt_r <= cycle_cnt_r + 16'd1;
      end else begin
         cycle_cnt_r <= cycle_cnt_r;
      end
   end

   assign bus.o_cycle_count = cycle_cnt_r;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;
   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_fail;
   int   n_checks;
   int   t;

   fft_stage_sequencer_if bus ();

   fft_stage_sequencer #(.LOG2_N(10), .DRAIN_CYCLES(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic advance_to(input int target);
      while (t < target) tick();
   endtask

   task automatic start_run();
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      t = 0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_valid"},  32'(bus.o_valid),  32'd0);
      check({pfx, "_busy"},   32'(bus.o_busy),   32'd0);
      check({pfx, "_done"},   32'(bus.o_done),   32'd0);
      check({pfx, "_addr1"},  32'(bus.o_addr1),  32'd0);
      check({pfx, "_addr2"},  32'(bus.o_addr2),  32'd0);
      check({pfx, "_stride"}, 32'(bus.o_stride), 32'd1);
      check({pfx, "_stage"},  32'(bus.o_stage),  32'd0);
      check({pfx, "_tw1"},    32'(bus.o_twiddle_offset1), 32'd0);
      check({pfx, "_tw2"},    32'(bus.o_twiddle_offset2), 32'd0);
      check({pfx, "_tw3"},    32'(bus.o_twiddle_offset3), 32'd0);
      check({pfx, "_tw4"},    32'(bus.o_twiddle_offset4), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check({pfx, "_cyc"},    32'(bus.o_cycle_count), 32'd0);
`endif
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_checks = 0; t = 0;
      bus.i_start = 1'b0;
      bus.i_stall = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      check_reset_vals("rst");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // no issue after reset release without a start
      repeat (3) tick();
      check("idle_valid", 32'(bus.o_valid), 32'd0);
      check("idle_busy",  32'(bus.o_busy),  32'd0);

      // ---------------- unstalled run ----------------
      start_run();
      advance_to(1);
      check("s0k0_valid", 32'(bus.o_valid), 32'd1);
      check("s0k0_busy",  32'(bus.o_busy),  32'd1);
      check("s0k0_addr1", 32'(bus.o_addr1), 32'd0);
      check("s0k0_addr2", 32'(bus.o_addr2), 32'd1);
      advance_to(6);
      check("s0k5_addr1",  32'(bus.o_addr1),  32'd10);
      check("s0k5_addr2",  32'(bus.o_addr2),  32'd11);
      check("s0k5_stride", 32'(bus.o_stride), 32'd1);
      check("s0k5_tw1", 32'(bus.o_twiddle_offset1), 32'd0);
      check("s0k5_tw4", 32'(bus.o_twiddle_offset4), 32'd0);
      advance_to(129);
      check("s0_drain_valid",  32'(bus.o_valid),  32'd0);
      check("s0_drain_stride", 32'(bus.o_stride), 32'd1);
      advance_to(133);
      check("s0_drain_end_valid", 32'(bus.o_valid), 32'd0);
      advance_to(134);
      check("s1k0_valid",  32'(bus.o_valid),  32'd1);
      check("s1k0_stage",  32'(bus.o_stage),  32'd1);
      check("s1k0_stride", 32'(bus.o_stride), 32'd2);
      check("s1k0_tw1", 32'(bus.o_twiddle_offset1), 32'd0);
      check("s1k0_tw2", 32'(bus.o_twiddle_offset2), 32'd256);
      check("s1k0_tw4", 32'(bus.o_twiddle_offset4), 32'd256);
      // start pulse while busy must be ignored
      advance_to(300);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      advance_to(538);
      check("s4k5_stage",  32'(bus.o_stage),  32'd4);
      check("s4k5_addr1",  32'(bus.o_addr1),  32'd9);
      check("s4k5_addr2",  32'(bus.o_addr2),  32'd13);
      check("s4k5_stride", 32'(bus.o_stride), 32'd16);
      check("s4k5_tw1", 32'(bus.o_twiddle_offset1), 32'd128);
      check("s4k5_tw2", 32'(bus.o_twiddle_offset2), 32'd160);
      check("s4k5_tw3", 32'(bus.o_twiddle_offset3), 32'd192);
      check("s4k5_tw4", 32'(bus.o_twiddle_offset4), 32'd224);
      advance_to(1325);
      check("s9k127_valid",  32'(bus.o_valid),  32'd1);
      check("s9k127_stage",  32'(bus.o_stage),  32'd9);
      check("s9k127_addr1",  32'(bus.o_addr1),  32'd127);
      check("s9k127_addr2",  32'(bus.o_addr2),  32'd255);
      check("s9k127_stride", 32'(bus.o_stride), 32'd512);
      check("s9k127_tw1", 32'(bus.o_twiddle_offset1), 32'd508);
      check("s9k127_tw2", 32'(bus.o_twiddle_offset2), 32'd509);
      check("s9k127_tw3", 32'(bus.o_twiddle_offset3), 32'd510);
      check("s9k127_tw4", 32'(bus.o_twiddle_offset4), 32'd511);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s9_drain_valid",  32'(bus.o_valid),  32'd0);
         check("s9_drain_done",   32'(bus.o_done),   32'd0);
         check("s9_drain_busy",   32'(bus.o_busy),   32'd1);
         check("s9_drain_stride", 32'(bus.o_stride), 32'd512);
      end
      tick();
      check("done_t1331", 32'(bus.o_done), 32'd1);
      check("done_busy",  32'(bus.o_busy), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("cyc_cnt_end", 32'(bus.o_cycle_count), 32'd1331);
`endif
      tick();
      check("done_pulse_end", 32'(bus.o_done), 32'd0);
      check("after_done_busy", 32'(bus.o_busy), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("cyc_cnt_hold", 32'(bus.o_cycle_count), 32'd1331);
`endif

      // ---------------- stalled run ----------------
      start_run();
      advance_to(307);
      check("s2k40_valid", 32'(bus.o_valid), 32'd1);
      check("s2k40_stage", 32'(bus.o_stage), 32'd2);
      check("s2k40_addr1", 32'(bus.o_addr1), 32'd80);
      check("s2k40_addr2", 32'(bus.o_addr2), 32'd81);
      check("s2k40_tw2",   32'(bus.o_twiddle_offset2), 32'd128);
      check("s2k40_tw4",   32'(bus.o_twiddle_offset4), 32'd384);
      check("s2k40_stride", 32'(bus.o_stride), 32'd4);
      bus.i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", 32'(bus.o_valid), 32'd0);
         check("stall_addr1", 32'(bus.o_addr1), 32'd80);
         check("stall_addr2", 32'(bus.o_addr2), 32'd81);
         check("stall_tw4",   32'(bus.o_twiddle_offset4), 32'd384);
      end
      bus.i_stall = 1'b0;
      tick();
      check("resume_valid", 32'(bus.o_valid), 32'd1);
      check("resume_addr1", 32'(bus.o_addr1), 32'd82);
      check("resume_addr2", 32'(bus.o_addr2), 32'd83);
      while (bus.o_done !== 1'b1 && t < 1400) tick();
      check("stall_done_time", 32'(t), 32'd1334);

      // ---------------- reset mid-transform ----------------
      tick();
      start_run();
      advance_to(820);
      check("s6k21_stage", 32'(bus.o_stage), 32'd6);
      check("s6k21_addr1", 32'(bus.o_addr1), 32'd37);
      check("s6k21_addr2", 32'(bus.o_addr2), 32'd53);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      #2 rst_n = 1'b1;
      repeat (4) tick();
      check("postrst_valid", 32'(bus.o_valid), 32'd0);
      check("postrst_busy",  32'(bus.o_busy),  32'd0);
      start_run();
      advance_to(1);
      check("restart_valid", 32'(bus.o_valid), 32'd1);
      check("restart_stage", 32'(bus.o_stage), 32'd0);
      check("restart_addr1", 32'(bus.o_addr1), 32'd0);
      check("restart_addr2", 32'(bus.o_addr2), 32'd1);
      advance_to(2);
      check("restart_k1_addr1", 32'(bus.o_addr1), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter LOG2_N, default 10: transform size N = 2^LOG2_N complex samples, 4 samples per 128-bit word, N/8 word pairs per stage.
REQ-002 Parameter DRAIN_CYCLES, default 5: idle cycles after each stage's last issue, which lets datapath writeback retire.
REQ-003 clk  in  1: single clock, rising edge.
REQ-004 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 i_start  in  1: start pulse, sampled only in IDLE.
REQ-006 i_stall  in  1: memory-port hold; suppresses issue while high.
REQ-007 o_addr1, o_addr2  out  8 each: read word addresses to the datapath.
REQ-008 o_valid  out  1: the issued pair is valid.
REQ-009 o_stride  out  10: butterfly span s = 2^stage, in samples.
REQ-010 o_twiddle_offset1..4  out  9 each: twiddle index for butterflies 1-4.
REQ-011 o_stage  out  4: current stage, 0..LOG2_N-1.
REQ-012 o_busy  out  1: high in any state except IDLE; o_done  out  1: one-cycle completion pulse.

Function
REQ-013 FSM states are IDLE, ISSUE, DRAIN, DONE; all outputs are registered.
REQ-014 IDLE->ISSUE occurs on i_start, with stage=0 and pair k=0; i_start outside IDLE is ignored.
REQ-015 ISSUE: each non-stalled cycle emits pair k with o_valid=1, then k increments; after k=N/8-1 the FSM goes to DRAIN.
REQ-016 i_stall high in ISSUE: o_valid=0, k holds, addresses/twiddles hold their last value; issue resumes the cycle after stall falls.
REQ-017 DRAIN counts DRAIN_CYCLES cycles with o_valid=0 and ignores i_stall, then goes to ISSUE with stage+1 and k=0, or to DONE if stage=LOG2_N-1.
REQ-018 DONE lasts one cycle: o_done=1, then IDLE.
REQ-019 Span in words sw = max(1, s>>2); group g = k / sw, offset o = k mod sw.
REQ-020 o_addr1 = 2*sw*g + o, and o_addr2 = o_addr1 + sw; this gives 2k/2k+1 for stages 0-2.
REQ-021 Butterfly b (1..4) top sample mod s, written r_b, is: 0 for s=1; (b-1)&1 for s=2; 4*o+(b-1) for s>=4.
REQ-022 o_twiddle_offsetb = r_b << (LOG2_N-1-stage), truncated to 9 bits.
REQ-023 o_stride = 1<<stage while o_valid=1; it holds its value in DRAIN.
REQ-024 Unstalled latency: first o_valid of stage n occurs 1+n*(N/8+DRAIN_CYCLES) cycles after the i_start edge.
REQ-025 Unstalled total (N=1024, DRAIN_CYCLES=5): o_done occurs 1331 cycles after i_start.

Reset
REQ-026 rst_n low, at any time including mid-transform, forces IDLE immediately.
REQ-027 Reset values: o_valid=0, o_busy=0, o_done=0, o_addr1=0, o_addr2=0, o_stride=1, o_stage=0, all twiddles=0, k and drain counters=0.
REQ-028 After reset release, no issue occurs until a new i_start.

Configuration
REQ-029 With FFT_SEQ_PERF_CNT_EN defined, add output o_cycle_count (16 bits): cleared on i_start, increments each busy cycle, saturates at 0xFFFF, holds after o_done, resets to 0.
REQ-030 Without FFT_SEQ_PERF_CNT_EN, the port and counter do not exist.

Verification
REQ-031 Stage 0, k=5: o_addr1=10, o_addr2=11, o_stride=1, all twiddles=0.
REQ-032 Stage 4, k=5: o_addr1=9, o_addr2=13, o_stride=16, twiddles=128,160,192,224.
REQ-033 Stage 9, k=127: o_addr1=127, o_addr2=255, o_stride=512, twiddles=508,509,510,511; 5 idle cycles then o_done.
REQ-034 i_stall high 3 cycles at stage 2, k=40: o_valid=0 for 3 cycles, the pair (80,81) is held, and o_done is delayed to cycle 1334.
REQ-035 rst_n pulsed low mid stage 6: outputs take reset values in the same cycle; a later i_start restarts at stage 0, k=0; i_start pulsed during busy has no effect.
REQ-036 With FFT_SEQ_PERF_CNT_EN, an unstalled run ends with o_cycle_count=1331.
